// File: rtl/regfile_wb_arbiter_if.sv
// Bundle between the execution-unit result sources, the writeback arbiter and
// the register file write ports.
interface regfile_wb_arbiter_if #(
  parameter int REG_NUM    = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SRC_NUM    = 6,
  parameter int WRITE_NUM  = 4
);
  localparam int AW = $clog2(REG_NUM);

  logic [SRC_NUM-1:0]              srcValid;
  logic [AW*SRC_NUM-1:0]           srcAddr;
  logic [DATA_WIDTH*SRC_NUM-1:0]   srcData;
  logic [SRC_NUM-1:0]              srcReady;
  logic [WRITE_NUM-1:0]            writeEnable;
  logic [AW*WRITE_NUM-1:0]         writeAddr;
  logic [DATA_WIDTH*WRITE_NUM-1:0] dataInputs;

  // Source/regfile side: drives results, observes acceptance and writes.
  modport master (
    output srcValid, srcAddr, srcData,
    input  srcReady, writeEnable, writeAddr, dataInputs
  );

  // Arbiter side.
  modport slave (
    input  srcValid, srcAddr, srcData,
    output srcReady, writeEnable, writeAddr, dataInputs
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: round-robin packs up to WRITE_NUM source results per cycle
// onto registered register-file write ports, never two writes to one register.
module regfile_wb_arbiter #(
  parameter int REG_NUM    = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SRC_NUM    = 6,
  parameter int WRITE_NUM  = 4
) (
  input  logic                 clk,
  input  logic                 rstN,
  regfile_wb_arbiter_if.slave  bus
);
  localparam int AW = $clog2(REG_NUM);
  localparam int PW = (SRC_NUM > 1) ? $clog2(SRC_NUM) : 1;
  localparam int CW = $clog2(WRITE_NUM + 1);

  logic [AW-1:0]         src_addr [SRC_NUM];
  logic [DATA_WIDTH-1:0] src_data [SRC_NUM];

  logic [PW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [WRITE_NUM-1:0]  wr_en_q, wr_en_d;
  logic [AW-1:0]         wr_addr_q [WRITE_NUM];
  logic [AW-1:0]         wr_addr_d [WRITE_NUM];
  logic [DATA_WIDTH-1:0] wr_data_q [WRITE_NUM];
  logic [DATA_WIDTH-1:0] wr_data_d [WRITE_NUM];

  logic [SRC_NUM-1:0]    grant;
  logic [PW:0]           scan_pos;
  logic [PW-1:0]         scan_idx;
  logic [PW-1:0]         last_idx;
  logic                  any_grant;
  logic [CW-1:0]         used;
  logic [REG_NUM-1:0]    taken;

  genvar gi;
  generate
    for (gi = 0; gi < SRC_NUM; gi++) begin : g_src
      assign src_addr[gi] = bus.srcAddr[AW*gi +: AW];
      assign src_data[gi] = bus.srcData[DATA_WIDTH*gi +: DATA_WIDTH];
    end
    for (gi = 0; gi < WRITE_NUM; gi++) begin : g_port
      assign bus.writeAddr[AW*gi +: AW]                 = wr_addr_q[gi];
      assign bus.dataInputs[DATA_WIDTH*gi +: DATA_WIDTH] = wr_data_q[gi];
    end
  endgenerate

  always_comb begin
    grant     = '0;
    scan_pos  = '0;
    scan_idx  = '0;
    last_idx  = '0;
    any_grant = 1'b0;
    used      = '0;
    taken     = '0;
    wr_en_d   = '0;
    for (int p = 0; p < WRITE_NUM; p++) begin
      wr_addr_d[p] = '0;
      wr_data_d[p] = '0;
    end

    for (int k = 0; k < SRC_NUM; k++) begin
      scan_pos = {1'b0, rr_ptr_q} + (PW+1)'(k);
      if (scan_pos >= (PW+1)'(SRC_NUM)) begin
        scan_pos = scan_pos - (PW+1)'(SRC_NUM);
      end
      scan_idx = scan_pos[PW-1:0];
      if (bus.srcValid[scan_idx]) begin
        // r0 results are consumed without occupying a port.
        if (src_addr[scan_idx] == '0) begin
          grant[scan_idx] = 1'b1;
          any_grant       = 1'b1;
          last_idx        = scan_idx;
        end else if (used < CW'(WRITE_NUM) && !taken[src_addr[scan_idx]]) begin
          grant[scan_idx]          = 1'b1;
          any_grant                = 1'b1;
          last_idx                 = scan_idx;
          taken[src_addr[scan_idx]] = 1'b1;
          for (int p = 0; p < WRITE_NUM; p++) begin
            if (used == CW'(p)) begin
              wr_en_d[p]   = 1'b1;
              wr_addr_d[p] = src_addr[scan_idx];
              wr_data_d[p] = src_data[scan_idx];
            end
          end
          used = used + 1'b1;
        end
      end
    end

    rr_ptr_d = rr_ptr_q;
    if (any_grant) begin
      rr_ptr_d = (last_idx == PW'(SRC_NUM - 1)) ? '0 : last_idx + 1'b1;
    end
  end

  assign bus.srcReady    = rstN ? grant : '0;
  assign bus.writeEnable = wr_en_q;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      rr_ptr_q <= '0;
      wr_en_q  <= '0;
      for (int p = 0; p < WRITE_NUM; p++) begin
        wr_addr_q[p] <= '0;
        wr_data_q[p] <= '0;
      end
    end else begin
      rr_ptr_q <= rr_ptr_d;
      wr_en_q  <= wr_en_d;
      for (int p = 0; p < WRITE_NUM; p++) begin
        wr_addr_q[p] <= wr_addr_d[p];
        wr_data_q[p] <= wr_data_d[p];
      end
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized scoreboard bench for regfile_wb_arbiter with directed scenarios
// and a queue-based reference model of the grant scan.
module tb_regfile_wb_arbiter;
  localparam int REG_NUM    = 32;
  localparam int DATA_WIDTH = 32;
  localparam int SRC_NUM    = 6;
  localparam int WRITE_NUM  = 4;
  localparam int AW         = $clog2(REG_NUM);

  logic clk = 1'b0;
  logic rstN;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(
    .REG_NUM(REG_NUM), .DATA_WIDTH(DATA_WIDTH), .SRC_NUM(SRC_NUM), .WRITE_NUM(WRITE_NUM)
  ) bus ();

  regfile_wb_arbiter #(
    .REG_NUM(REG_NUM), .DATA_WIDTH(DATA_WIDTH), .SRC_NUM(SRC_NUM), .WRITE_NUM(WRITE_NUM)
  ) dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus.slave)
  );

  typedef struct {
    int                              cyc;
    logic [WRITE_NUM-1:0]            en;
    logic [AW*WRITE_NUM-1:0]         addr;
    logic [DATA_WIDTH*WRITE_NUM-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cycle    = 0;

  // Pending result held by each source until accepted.
  bit                    p_valid [SRC_NUM];
  logic [AW-1:0]         p_addr  [SRC_NUM];
  logic [DATA_WIDTH-1:0] p_data  [SRC_NUM];
  logic [SRC_NUM-1:0]    acc_mask = '0;

  // Reference model state.
  int                 rr = 0;
  int                 m_used;
  int                 m_last;
  int                 m_idx;
  bit                 m_clash;
  logic [AW-1:0]      m_taken[$];
  logic [SRC_NUM-1:0] m_ready;
  exp_t               m_e;
  exp_t               mon_e;

  always @(posedge clk) cycle++;

  task automatic check(string nm, logic [255:0] act, logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", nm, cycle, act, exp);
    end
  endtask

  // Model: a round-robin walk starting at rr, keeping a list of registers
  // already claimed this cycle.
  always @(negedge clk) begin
    if (!rstN) begin
      exp_q.delete();
      rr       = 0;
      acc_mask = '0;
      check("reset_ready", bus.srcReady, 0);
      check("reset_wen",   bus.writeEnable, 0);
      check("reset_waddr", bus.writeAddr, 0);
      check("reset_wdata", bus.dataInputs, 0);
    end else begin
      m_used  = 0;
      m_last  = -1;
      m_ready = '0;
      m_taken.delete();
      m_e.cyc  = cycle + 1;
      m_e.en   = '0;
      m_e.addr = '0;
      m_e.data = '0;
      for (int k = 0; k < SRC_NUM; k++) begin
        m_idx = (rr + k) % SRC_NUM;
        if (p_valid[m_idx]) begin
          if (p_addr[m_idx] == 0) begin
            m_ready[m_idx] = 1'b1;
            m_last = m_idx;
          end else if (m_used < WRITE_NUM) begin
            m_clash = 1'b0;
            foreach (m_taken[j]) if (m_taken[j] == p_addr[m_idx]) m_clash = 1'b1;
            if (!m_clash) begin
              m_ready[m_idx] = 1'b1;
              m_last = m_idx;
              m_taken.push_back(p_addr[m_idx]);
              m_e.en[m_used] = 1'b1;
              m_e.addr[AW*m_used +: AW] = p_addr[m_idx];
              m_e.data[DATA_WIDTH*m_used +: DATA_WIDTH] = p_data[m_idx];
              m_used++;
            end
          end
        end
      end
      check("src_ready", bus.srcReady, m_ready);
      acc_mask = m_ready;
      if (m_last >= 0) rr = (m_last + 1) % SRC_NUM;
      if (m_used > 0) exp_q.push_back(m_e);
    end
  end

  // Monitor: compares whenever the DUT presents a write.
  always @(negedge clk) begin
    if (rstN) begin
      if (exp_q.size() > 0 && exp_q[0].cyc < cycle) begin
        n_checks++;
        n_fail++;
        $display("FAIL missing_write @cycle %0d: got no write, expected en=%b at cycle %0d",
                 cycle, exp_q[0].en, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      if (bus.writeEnable != 0) begin
        if (exp_q.size() == 0 || exp_q[0].cyc != cycle) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write @cycle %0d: got en=%b expected none",
                   cycle, bus.writeEnable);
        end else begin
          mon_e = exp_q.pop_front();
          $display("cycle %0d write en=%b addr=%h data=%h", cycle,
                   bus.writeEnable, bus.writeAddr, bus.dataInputs);
          check("write_en",   bus.writeEnable, mon_e.en);
          check("write_addr", bus.writeAddr,   mon_e.addr);
          check("write_data", bus.dataInputs,  mon_e.data);
        end
      end
    end
  end

  task automatic drive();
    for (int i = 0; i < SRC_NUM; i++) begin
      bus.srcValid[i]                          = p_valid[i];
      bus.srcAddr[AW*i +: AW]                  = p_addr[i];
      bus.srcData[DATA_WIDTH*i +: DATA_WIDTH]  = p_data[i];
    end
  endtask

  task automatic load(int i, int a, logic [DATA_WIDTH-1:0] d);
    p_valid[i] = 1'b1;
    p_addr[i]  = AW'(a);
    p_data[i]  = d;
  endtask

  task automatic retire();
    for (int i = 0; i < SRC_NUM; i++) if (acc_mask[i]) p_valid[i] = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    retire();
    drive();
  endtask

  function automatic bit any_pending();
    for (int i = 0; i < SRC_NUM; i++) if (p_valid[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drain(int budget);
    int n = 0;
    while (any_pending() && n < budget) begin
      tick();
      n++;
    end
    if (any_pending()) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout @cycle %0d: got sources still pending expected all accepted", cycle);
      for (int i = 0; i < SRC_NUM; i++) p_valid[i] = 1'b0;
      drive();
    end
    tick();
    tick();
  endtask

  task automatic reset_pulse();
    @(posedge clk);
    #1;
    retire();
    rstN = 1'b0;
    drive();
    @(negedge clk);
    @(posedge clk);
    #1;
    rstN = 1'b1;
  endtask

  task automatic load_ascending();
    for (int i = 0; i < SRC_NUM; i++) load(i, i + 1, 32'hA000_0000 + 32'(i + 1));
    drive();
  endtask

  initial begin
    for (int i = 0; i < SRC_NUM; i++) begin
      p_valid[i] = 1'b0;
      p_addr[i]  = '0;
      p_data[i]  = '0;
    end

    // Reset with every source asserting valid.
    rstN = 1'b0;
    for (int i = 0; i < SRC_NUM; i++) load(i, i + 3, 32'(i));
    drive();
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < SRC_NUM; i++) p_valid[i] = 1'b0;
    drive();
    rstN = 1'b1;

    // Single result from src2.
    tick();
    load(2, 5, 32'hDEAD_BEEF);
    drive();
    drain(20);

    // All six sources, two-cycle packing.
    reset_pulse();
    load_ascending();
    drain(20);

    // Reset in the middle of the same burst, then restart from src0.
    reset_pulse();
    load_ascending();
    tick();
    reset_pulse();
    load_ascending();
    drain(20);

    // Same destination from two sources.
    reset_pulse();
    load(0, 7, 32'h1111_0000);
    load(1, 7, 32'h2222_0000);
    drive();
    drain(20);

    // r0 result alongside a full set of port writes.
    reset_pulse();
    load(0, 0, 32'hFFFF_FFFF);
    for (int i = 1; i <= 4; i++) load(i, 7 + i, 32'hB000_0000 + 32'(i));
    drive();
    drain(20);

    // Random traffic with narrow address range to provoke conflicts.
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 99) == 0) begin
        reset_pulse();
      end else begin
        @(posedge clk);
        #1;
        retire();
      end
      for (int i = 0; i < SRC_NUM; i++) begin
        if (!p_valid[i] && $urandom_range(0, 1) == 1) begin
          load(i, ($urandom_range(0, 3) == 0) ? $urandom_range(0, REG_NUM - 1)
                                              : $urandom_range(0, 7),
               $urandom);
        end
      end
      drive();
    end
    drain(50);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
